// File: rtl/burst_job_scheduler.sv
// Descriptor-queue controller: CPU stages and pushes burst jobs, the FSM replays
// each one into the DMA engine's CSR slave, polls DONE, clears it and counts completions.
module burst_job_scheduler #(
    parameter int QUEUE_DEPTH = 8,
    parameter int LEN_ALIGN   = 1024,
    parameter int POLL_GAP    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        avs_write,
    input  logic        avs_read,
    input  logic [2:0]  avs_address,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic [2:0]  cm_address,
    output logic        cm_write,
    output logic        cm_read,
    output logic [31:0] cm_writedata,
    input  logic [31:0] cm_readdata,
    input  logic        cm_waitrequest,
    output logic        irq
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = $clog2(POLL_GAP + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_GAP);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [31:0]      ALIGN_W  = 32'(LEN_ALIGN);

    typedef enum logic [3:0] {
        ST_IDLE, ST_WR_SRC, ST_WR_DST, ST_WR_LEN, ST_WR_COEFF,
        ST_WR_START, ST_GAP, ST_POLL, ST_CLR_DONE
    } state_t;

    function automatic logic len_ok(input logic [31:0] len);
        return (len != 32'd0) && ((len % ALIGN_W) == 32'd0);
    endfunction

    logic [31:0] src_r, dst_r, len_r, coeff_r, done_cnt_r;
    logic        enable_r, irq_en_r, overflow_r, len_err_r, irq_r;
    logic [31:0] q_src_r [QUEUE_DEPTH];
    logic [31:0] q_dst_r [QUEUE_DEPTH];
    logic [31:0] q_len_r [QUEUE_DEPTH];
    logic [31:0] q_coeff_r [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [31:0] act_dst_r, act_len_r, act_coeff_r;
    state_t      state_r, state_next_s;
    logic [GAP_W-1:0] gap_cnt_r, gap_cnt_next_s;
    logic        cm_write_r, cm_read_r, cm_write_next_s, cm_read_next_s;
    logic [2:0]  cm_address_r, cm_address_next_s;
    logic [31:0] cm_writedata_r, cm_writedata_next_s;
    logic        push_req_s, push_ok_s, len_bad_s, full_s, clr_s, pop_s, complete_s;
    logic        unused_ok_s;

    assign unused_ok_s  = ^{avs_read, cm_readdata[31:1]};
    assign cm_write     = cm_write_r;
    assign cm_read      = cm_read_r;
    assign cm_address   = cm_address_r;
    assign cm_writedata = cm_writedata_r;
    assign irq          = irq_r;

    // CPU write decode; a push that meets a full queue is rejected even if a pop coincides
    always_comb begin
        push_req_s = avs_write && (avs_address == 3'd4);
        len_bad_s  = push_req_s && !len_ok(len_r);
        full_s     = (count_r == FULL_CNT);
        push_ok_s  = push_req_s && len_ok(len_r) && !full_s;
        clr_s      = avs_write && (avs_address == 3'd6);
    end

    // CPU read mux, zero wait state
    always_comb begin
        case (avs_address)
            3'd0:    avs_readdata = src_r;
            3'd1:    avs_readdata = dst_r;
            3'd2:    avs_readdata = len_r;
            3'd3:    avs_readdata = coeff_r;
            3'd5:    avs_readdata = {21'd0, len_err_r, overflow_r, (state_r != ST_IDLE), 8'(count_r)};
            3'd6:    avs_readdata = done_cnt_r;
            3'd7:    avs_readdata = {30'd0, irq_en_r, enable_r};
            default: avs_readdata = 32'd0;
        endcase
    end

    // CSR staging, control, sticky flags, completion count and interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            src_r      <= 32'd0;
            dst_r      <= 32'd0;
            len_r      <= 32'd0;
            coeff_r    <= 32'd1;
            enable_r   <= 1'b0;
            irq_en_r   <= 1'b0;
            overflow_r <= 1'b0;
            len_err_r  <= 1'b0;
            done_cnt_r <= 32'd0;
            irq_r      <= 1'b0;
        end else begin
            if (avs_write) begin
                case (avs_address)
                    3'd0:    src_r   <= avs_writedata;
                    3'd1:    dst_r   <= avs_writedata;
                    3'd2:    len_r   <= avs_writedata;
                    3'd3:    coeff_r <= avs_writedata;
                    3'd7: begin
                        enable_r <= avs_writedata[0];
                        irq_en_r <= avs_writedata[1];
                    end
                    default: ;
                endcase
            end
            if (len_bad_s)                          len_err_r  <= 1'b1;
            else if (clr_s)                         len_err_r  <= 1'b0;
            if (push_req_s && !len_bad_s && full_s) overflow_r <= 1'b1;
            else if (clr_s)                         overflow_r <= 1'b0;
            if (complete_s)                         done_cnt_r <= done_cnt_r + 32'd1;
            // a completion in the same cycle as the clear keeps irq asserted
            if (complete_s && irq_en_r)             irq_r      <= 1'b1;
            else if (clr_s)                         irq_r      <= 1'b0;
        end
    end

    // Descriptor storage; contents are only meaningful behind the pointers
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            q_src_r[wr_ptr_r]   <= src_r;
            q_dst_r[wr_ptr_r]   <= dst_r;
            q_len_r[wr_ptr_r]   <= len_r;
            q_coeff_r[wr_ptr_r] <= coeff_r;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)     rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Sequencer next state; engine bus outputs are computed here and registered below
    always_comb begin
        state_next_s        = state_r;
        gap_cnt_next_s      = gap_cnt_r;
        pop_s               = 1'b0;
        complete_s          = 1'b0;
        cm_write_next_s     = 1'b0;
        cm_read_next_s      = 1'b0;
        cm_address_next_s   = cm_address_r;
        cm_writedata_next_s = cm_writedata_r;
        case (state_r)
            ST_IDLE: begin
                if (enable_r && (count_r != CNT_ZERO)) begin
                    pop_s               = 1'b1;
                    state_next_s        = ST_WR_SRC;
                    cm_write_next_s     = 1'b1;
                    cm_address_next_s   = 3'd2;
                    cm_writedata_next_s = q_src_r[rd_ptr_r];
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WR_SRC: begin
                if (!cm_waitrequest) begin
                    state_next_s        = ST_WR_DST;
                    cm_write_next_s     = 1'b1;
                    cm_address_next_s   = 3'd3;
                    cm_writedata_next_s = act_dst_r;
                end else begin
                    cm_write_next_s = 1'b1;
                end
            end
            ST_WR_DST: begin
                if (!cm_waitrequest) begin
                    state_next_s        = ST_WR_LEN;
                    cm_write_next_s     = 1'b1;
                    cm_address_next_s   = 3'd4;
                    cm_writedata_next_s = act_len_r;
                end else begin
                    cm_write_next_s = 1'b1;
                end
            end
            ST_WR_LEN: begin
                if (!cm_waitrequest) begin
                    state_next_s        = ST_WR_COEFF;
                    cm_write_next_s     = 1'b1;
                    cm_address_next_s   = 3'd5;
                    cm_writedata_next_s = act_coeff_r;
                end else begin
                    cm_write_next_s = 1'b1;
                end
            end
            ST_WR_COEFF: begin
                if (!cm_waitrequest) begin
                    state_next_s        = ST_WR_START;
                    cm_write_next_s     = 1'b1;
                    cm_address_next_s   = 3'd0;
                    cm_writedata_next_s = 32'd1;
                end else begin
                    cm_write_next_s = 1'b1;
                end
            end
            ST_WR_START: begin
                if (!cm_waitrequest) begin
                    state_next_s   = ST_GAP;
                    gap_cnt_next_s = GAP_LOAD;
                end else begin
                    cm_write_next_s = 1'b1;
                end
            end
            ST_GAP: begin
                // counter walks POLL_GAP..1, so the bus stays idle for POLL_GAP cycles
                if (gap_cnt_r <= GAP_ONE) begin
                    state_next_s      = ST_POLL;
                    cm_read_next_s    = 1'b1;
                    cm_address_next_s = 3'd1;
                end else begin
                    gap_cnt_next_s = gap_cnt_r - GAP_ONE;
                end
            end
            ST_POLL: begin
                if (!cm_waitrequest) begin
                    if (cm_readdata[0]) begin
                        state_next_s        = ST_CLR_DONE;
                        cm_write_next_s     = 1'b1;
                        cm_address_next_s   = 3'd1;
                        cm_writedata_next_s = 32'd1;
                    end else begin
                        state_next_s   = ST_GAP;
                        gap_cnt_next_s = GAP_LOAD;
                    end
                end else begin
                    cm_read_next_s = 1'b1;
                end
            end
            ST_CLR_DONE: begin
                if (!cm_waitrequest) begin
                    complete_s   = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    cm_write_next_s = 1'b1;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Sequencer state, active descriptor copy and registered engine bus
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            gap_cnt_r      <= '0;
            act_dst_r      <= 32'd0;
            act_len_r      <= 32'd0;
            act_coeff_r    <= 32'd0;
            cm_write_r     <= 1'b0;
            cm_read_r      <= 1'b0;
            cm_address_r   <= 3'd0;
            cm_writedata_r <= 32'd0;
        end else begin
            state_r        <= state_next_s;
            gap_cnt_r      <= gap_cnt_next_s;
            cm_write_r     <= cm_write_next_s;
            cm_read_r      <= cm_read_next_s;
            cm_address_r   <= cm_address_next_s;
            cm_writedata_r <= cm_writedata_next_s;
            if (pop_s) begin
                act_dst_r   <= q_dst_r[rd_ptr_r];
                act_len_r   <= q_len_r[rd_ptr_r];
                act_coeff_r <= q_coeff_r[rd_ptr_r];
            end
        end
    end
endmodule
